status_reg_stack: RTL and testbench

STATUS_REG_STACK -- requirements
Module: status_reg_stack

---
 rtl/status_reg_stack.sv | 124 ++++++++++++
 tb/tb_status_reg_stack.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/status_reg_stack.sv
// status_reg_stack: WIDTH-bit status flag register with per-bit masked load
// and a DEPTH-entry LIFO shadow stack for saving and restoring the flags.
// Optional feature macro: STATUS_STACK_ERR_EN enables the sticky err flag
// (overflow / underflow tracking, cleared by clr_err, set wins over clear).
// Without the macro, err is tied to 0 and clr_err is ignored.
module status_reg_stack #(
  parameter int                 WIDTH     = 4,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             data_in,
  input  logic [WIDTH-1:0]             load_mask,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             data_out,
  output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Stack storage is intentionally not reset; only entries below depth_cnt
  // are ever read back, so stale contents are never observable.
  logic [WIDTH-1:0] stack_r [DEPTH];

  logic [WIDTH-1:0] data_out_r;
  logic [CW-1:0]    depth_cnt_r;
  logic             err_r;

  logic [WIDTH-1:0] masked_s;
  logic [WIDTH-1:0] data_next_s;
  logic [CW-1:0]    depth_next_s;
  logic [CW-1:0]    depth_dec_s;
  logic [IW-1:0]    wr_idx_s;
  logic [IW-1:0]    rd_idx_s;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic             ovf_s;
  logic             unf_s;
  logic             err_next_s;

  assign full_s      = (depth_cnt_r == CW'(DEPTH));
  assign empty_s     = (depth_cnt_r == {CW{1'b0}});
  assign depth_dec_s = depth_cnt_r - CW'(1);
  assign wr_idx_s    = depth_cnt_r[IW-1:0];
  assign rd_idx_s    = depth_dec_s[IW-1:0];

  // Push and pop together cancel out; misuse is only an unpaired request.
  assign do_push_s = push & ~pop & ~full_s;
  assign do_pop_s  = pop & ~push & ~empty_s;
  assign ovf_s     = push & ~pop & full_s;
  assign unf_s     = pop & ~push & empty_s;

  assign masked_s = (data_out_r & ~load_mask) | (data_in & load_mask);

  // Next flag value and stack depth; a real pop overrides the masked load.
  always_comb begin
    data_next_s  = masked_s;
    depth_next_s = depth_cnt_r;
    if (do_pop_s) begin
      data_next_s  = stack_r[rd_idx_s];
      depth_next_s = depth_dec_s;
    end else if (do_push_s) begin
      data_next_s  = masked_s;
      depth_next_s = depth_cnt_r + CW'(1);
    end else begin
      data_next_s  = masked_s;
      depth_next_s = depth_cnt_r;
    end
  end

`ifdef STATUS_STACK_ERR_EN
  // Sticky error: a new misuse event takes priority over a clear request.
  always_comb begin
    err_next_s = err_r;
    if (ovf_s || unf_s) begin
      err_next_s = 1'b1;
    end else if (clr_err) begin
      err_next_s = 1'b0;
    end else begin
      err_next_s = err_r;
    end
  end
`else
  logic unused_s;
  assign unused_s   = ^{clr_err, ovf_s, unf_s};
  assign err_next_s = 1'b0;
`endif

  // Flag, depth and error registers; reset aborts any push/pop in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_r  <= RESET_VAL;
      depth_cnt_r <= {CW{1'b0}};
      err_r       <= 1'b0;
    end else begin
      data_out_r  <= data_next_s;
      depth_cnt_r <= depth_next_s;
      err_r       <= err_next_s;
    end
  end

  // Save the pre-edge flags into the next free entry on a real push.
  always_ff @(posedge clk) begin
    if (do_push_s && !rst) begin
      stack_r[wr_idx_s] <= data_out_r;
    end
  end

  assign data_out  = data_out_r;
  assign depth_cnt = depth_cnt_r;
  assign err       = err_r;
  assign full      = full_s;
  assign empty     = empty_s;

endmodule

// File: tb/tb_status_reg_stack.sv
// Scoreboard bench for status_reg_stack (WIDTH=4, DEPTH=2, RESET_VAL=0101).
// The driver pushes hand-computed expectations into a queue; the monitor
// pops and compares after each rising edge or on an immediate-check event.
module tb_status_reg_stack;

  logic       clk;
  logic       rst;
  logic [3:0] data_in;
  logic [3:0] load_mask;
  logic       push;
  logic       pop;
  logic       clr_err;
  logic [3:0] data_out;
  logic [1:0] depth_cnt;
  logic       full;
  logic       empty;
  logic       err;

`ifdef STATUS_STACK_ERR_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  typedef struct {
    logic [3:0] d;
    logic [1:0] c;
    logic       r;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  event check_ev;

  status_reg_stack #(.WIDTH(4), .DEPTH(2), .RESET_VAL(4'b0101)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_mask(load_mask),
    .push(push), .pop(pop), .clr_err(clr_err), .data_out(data_out),
    .depth_cnt(depth_cnt), .full(full), .empty(empty), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", nm, act, req);
    end
  endtask

  // Monitor: compare every pending expectation against the DUT outputs.
  initial begin
    tests = 0;
    fails = 0;
    forever begin
      @(posedge clk or check_ev);
      #1;
      while (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        chk({x.nm, ".data_out"},  data_out,        x.d);
        chk({x.nm, ".depth_cnt"}, {2'b00, depth_cnt}, {2'b00, x.c});
        chk({x.nm, ".full"},      {3'b000, full},  {3'b000, (x.c == 2'd2)});
        chk({x.nm, ".empty"},     {3'b000, empty}, {3'b000, (x.c == 2'd0)});
        chk({x.nm, ".err"},       {3'b000, err},   {3'b000, x.r});
      end
    end
  end

  // One clocked transaction: drive at negedge, expect result after posedge.
  task automatic cyc(input string nm, input logic p, input logic o, input logic c,
                     input logic [3:0] din, input logic [3:0] m,
                     input logic [3:0] ed, input logic [1:0] ec, input logic er);
    exp_t x;
    @(negedge clk);
    push = p; pop = o; clr_err = c; data_in = din; load_mask = m;
    x.d = ed; x.c = ec; x.r = er; x.nm = nm;
    exp_q.push_back(x);
  endtask

  // Asynchronous check: expectation compared without waiting for a clock.
  task automatic now_chk(input string nm, input logic [3:0] ed, input logic [1:0] ec,
                         input logic er);
    exp_t x;
    x.d = ed; x.c = ec; x.r = er; x.nm = nm;
    exp_q.push_back(x);
    -> check_ev;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    data_in = 4'b0000; load_mask = 4'b0000;
    #3;
    now_chk("reset_init", 4'b0101, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc("first_edge_hold", 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0101, 2'd0, 1'b0);
    cyc("load_all_zero",   1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0);
    // Mid-cycle reset pulse acts immediately.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 now_chk("reset_async", 4'b0101, 2'd0, 1'b0);
    rst = 1'b0;
    cyc("clear_again",     1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0);
    cyc("masked_load",     1'b0, 1'b0, 1'b0, 4'b1111, 4'b1010, 4'b1010, 2'd0, 1'b0);
    cyc("mask_zero_hold",  1'b0, 1'b0, 1'b0, 4'b0101, 4'b0000, 4'b1010, 2'd0, 1'b0);
    // Push / pop round trip.
    cyc("rt_push",         1'b1, 1'b0, 1'b0, 4'b0001, 4'b1111, 4'b0001, 2'd1, 1'b0);
    cyc("rt_pop",          1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1010, 2'd0, 1'b0);
    // Overflow and underflow.
    cyc("ov_push1",        1'b1, 1'b0, 1'b0, 4'b0011, 4'b1111, 4'b0011, 2'd1, 1'b0);
    cyc("ov_push2",        1'b1, 1'b0, 1'b0, 4'b1100, 4'b1111, 4'b1100, 2'd2, 1'b0);
    cyc("ov_push3",        1'b1, 1'b0, 1'b0, 4'b0111, 4'b1111, 4'b0111, 2'd2, E);
    cyc("ov_clr",          1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0111, 2'd2, 1'b0);
    cyc("un_pop1",         1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0011, 2'd1, 1'b0);
    cyc("un_pop2",         1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1010, 2'd0, 1'b0);
    cyc("un_pop3",         1'b0, 1'b1, 1'b0, 4'b0110, 4'b0000, 4'b1010, 2'd0, E);
    cyc("un_clr",          1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1010, 2'd0, 1'b0);
    cyc("set_wins_clr",    1'b0, 1'b1, 1'b1, 4'b0001, 4'b0001, 4'b1011, 2'd0, E);
    cyc("clr_after",       1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 4'b1010, 2'd0, 1'b0);
    // Simultaneous push and pop.
    cyc("pp_push",         1'b1, 1'b0, 1'b0, 4'b1001, 4'b1111, 4'b1001, 2'd1, 1'b0);
    cyc("pp_both",         1'b1, 1'b1, 1'b0, 4'b0110, 4'b1111, 4'b0110, 2'd1, 1'b0);
    cyc("pp_pop_after",    1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1010, 2'd0, 1'b0);
    // Reset mid-operation aborts a pop.
    cyc("mo_push1",        1'b1, 1'b0, 1'b0, 4'b0001, 4'b1111, 4'b0001, 2'd1, 1'b0);
    cyc("mo_push2",        1'b1, 1'b0, 1'b0, 4'b0010, 4'b1111, 4'b0010, 2'd2, 1'b0);
    @(negedge clk);
    push = 1'b0; pop = 1'b1; clr_err = 1'b0; load_mask = 4'b0000;
    #2 rst = 1'b1;
    #1 now_chk("mo_reset", 4'b0101, 2'd0, 1'b0);
    @(negedge clk);
    #1 now_chk("mo_reset_hold", 4'b0101, 2'd0, 1'b0);
    rst = 1'b0;
    cyc("mo_underflow",    1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0101, 2'd0, E);
    cyc("mo_load",         1'b0, 1'b0, 1'b1, 4'b1110, 4'b1111, 4'b1110, 2'd0, 1'b0);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; load_mask = 4'b0000;
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
